// File: rtl/tree_pkg.sv
// Shared types and constants for the decision-tree traversal sequencer.
package tree_pkg;

   localparam int NODE_ADDR_W = 9;
   localparam int FEAT_W      = 64;
   localparam int NUM_FEAT    = 4;
   localparam int CLASS_W     = 2;
   localparam int FIDX_W      = $clog2(NUM_FEAT);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      ERR_OK      = 2'b00,
      ERR_DEPTH   = 2'b01,
      ERR_TIMEOUT = 2'b10,
      ERR_BADNODE = 2'b11
   } err_e;

   // A node with exactly one null child is malformed; both null is a legal back-edge to root.
   function automatic logic one_child_null(input logic [NODE_ADDR_W-1:0] l,
                                           input logic [NODE_ADDR_W-1:0] r);
      return (l == '0) != (r == '0);
   endfunction

endpackage

// File: rtl/feature_select_cmp.sv
// Picks one 64-bit feature out of the vector and compares it unsigned against the node threshold.
module feature_select_cmp
   import tree_pkg::*;
(
   input  logic [NUM_FEAT*FEAT_W-1:0] features_i,
   input  logic [FIDX_W-1:0]          feature_idx_i,
   input  logic [FEAT_W-1:0]          threshold_i,
   output logic                       go_left_o
);

   logic [FEAT_W-1:0] selected;

   always_comb begin
      selected = features_i[feature_idx_i*FEAT_W +: FEAT_W];
   end

   assign go_left_o = (selected <= threshold_i);

endmodule

// File: rtl/tree_traversal_ctrl.sv
// Walks one decision tree from root to leaf against a registered feature vector,
// driving the node memory and reporting class/depth/error through a valid/ready port.
module tree_traversal_ctrl
   import tree_pkg::*;
#(
   parameter int unsigned           MAX_DEPTH    = 16,
   parameter int unsigned           WAIT_TIMEOUT = 8,
   parameter logic [NODE_ADDR_W-1:0] ROOT_ADDR   = 9'd0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [NUM_FEAT*FEAT_W-1:0] in_features,
   output logic [NODE_ADDR_W-1:0]     node_addr,
   output logic                       read_enable,
   input  logic [FIDX_W-1:0]          feature_idx,
   input  logic [FEAT_W-1:0]          threshold,
   input  logic [NODE_ADDR_W-1:0]     left_child,
   input  logic [NODE_ADDR_W-1:0]     right_child,
   input  logic [CLASS_W-1:0]         prediction,
   input  logic                       is_leaf,
   input  logic                       data_valid,
   output logic                       result_valid,
   input  logic                       result_ready,
   output logic [CLASS_W-1:0]         result_class,
   output logic [1:0]                 result_error,
   output logic [7:0]                 result_depth,
   output logic                       busy
);

   localparam logic [7:0] MAX_DEPTH_C = 8'(MAX_DEPTH);
   localparam logic [7:0] TIMEOUT_C   = 8'(WAIT_TIMEOUT);

   state_e                      state_q, state_d;
   logic [NODE_ADDR_W-1:0]      node_addr_q, node_addr_d;
   logic [NUM_FEAT*FEAT_W-1:0]  feat_q, feat_d;
   logic [7:0]                  depth_q, depth_d;
   logic [7:0]                  tmo_q, tmo_d;
   logic [CLASS_W-1:0]          class_q, class_d;
   err_e                        err_q, err_d;
   logic                        go_left;

   feature_select_cmp u_cmp (
      .features_i    (feat_q),
      .feature_idx_i (feature_idx),
      .threshold_i   (threshold),
      .go_left_o     (go_left)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         node_addr_q <= ROOT_ADDR;
         feat_q      <= '0;
         depth_q     <= '0;
         tmo_q       <= '0;
         class_q     <= '0;
         err_q       <= ERR_OK;
      end else begin
         state_q     <= state_d;
         node_addr_q <= node_addr_d;
         feat_q      <= feat_d;
         depth_q     <= depth_d;
         tmo_q       <= tmo_d;
         class_q     <= class_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      node_addr_d = node_addr_q;
      feat_d      = feat_q;
      depth_d     = depth_q;
      tmo_d       = tmo_q;
      class_d     = class_q;
      err_d       = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               feat_d      = in_features;
               node_addr_d = ROOT_ADDR;
               depth_d     = '0;
               class_d     = '0;
               err_d       = ERR_OK;
               state_d     = ST_FETCH;
            end
         end
         ST_FETCH: begin
            depth_d = depth_q + 8'd1;
            tmo_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // Leaf wins over malformed-node and depth checks, so a leaf at MAX_DEPTH still classifies.
            if (data_valid) begin
               if (is_leaf) begin
                  class_d = prediction;
                  err_d   = ERR_OK;
                  state_d = ST_DONE;
               end else if (one_child_null(left_child, right_child)) begin
                  err_d   = ERR_BADNODE;
                  state_d = ST_DONE;
               end else if (depth_q == MAX_DEPTH_C) begin
                  err_d   = ERR_DEPTH;
                  state_d = ST_DONE;
               end else begin
                  node_addr_d = go_left ? left_child : right_child;
                  state_d     = ST_FETCH;
               end
            end else begin
               tmo_d = tmo_q + 8'd1;
               if (tmo_q + 8'd1 == TIMEOUT_C) begin
                  err_d   = ERR_TIMEOUT;
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (result_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign in_ready     = (state_q == ST_IDLE);
   assign busy         = (state_q != ST_IDLE);
   assign read_enable  = (state_q == ST_FETCH);
   assign result_valid = (state_q == ST_DONE);
   assign node_addr    = node_addr_q;
   assign result_class = class_q;
   assign result_error = err_q;
   assign result_depth = depth_q;

endmodule

// File: tb/tb_tree_traversal_ctrl.sv
// Bench for tree_traversal_ctrl: node-memory model, directed table, corner sequences, random walks.
`timescale 1ns/1ps
module tb_tree_traversal_ctrl;

   localparam int MAXD = 4;
   localparam int TMO  = 8;

   typedef struct packed {
      logic [1:0]  fidx;
      logic [63:0] thr;
      logic [8:0]  l;
      logic [8:0]  r;
      logic [1:0]  pred;
      logic        leaf;
   } node_t;

   typedef struct {
      int           tree;
      logic [255:0] feat;
      logic [1:0]   cls;
      logic [1:0]   err;
      int           dep;
      int           lat;
      int           reads;
      int           last;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [255:0] in_features = '0;
   logic [8:0]   node_addr;
   logic         read_enable;
   logic [1:0]   feature_idx;
   logic [63:0]  threshold;
   logic [8:0]   left_child, right_child;
   logic [1:0]   prediction;
   logic         is_leaf;
   logic         data_valid;
   logic         result_valid;
   logic         result_ready = 1'b1;
   logic [1:0]   result_class, result_error;
   logic [7:0]   result_depth;
   logic         busy;

   int total = 0;
   int bad   = 0;

   tree_traversal_ctrl #(.MAX_DEPTH(MAXD), .WAIT_TIMEOUT(TMO), .ROOT_ADDR(9'd0)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_features(in_features), .node_addr(node_addr), .read_enable(read_enable),
      .feature_idx(feature_idx), .threshold(threshold), .left_child(left_child),
      .right_child(right_child), .prediction(prediction), .is_leaf(is_leaf),
      .data_valid(data_valid), .result_valid(result_valid), .result_ready(result_ready),
      .result_class(result_class), .result_error(result_error),
      .result_depth(result_depth), .busy(busy)
   );

   always #5 clk = ~clk;

   // ---------------- node memory model (1-cycle latency, optional extra delay) -------------
   node_t      mem [512];
   logic       mem_stall = 1'b0;
   logic       inj_dv = 1'b0;
   logic [8:0] stall_addr = 9'h1FF;
   int         dly_max = 0;
   logic       resp_pend = 1'b0;
   int         resp_cnt = 0;
   logic [8:0] resp_addr = '0;
   int         nreads = 0;
   logic [8:0] last_read = '0;
   logic [8:0] first_read = '0;

   initial begin
      data_valid = 1'b0; feature_idx = '0; threshold = '0;
      left_child = '0; right_child = '0; prediction = '0; is_leaf = 1'b0;
      forever begin
         @(negedge clk);
         if (read_enable === 1'b1) begin
            resp_pend = 1'b1;
            resp_cnt  = (dly_max > 0) ? $urandom_range(0, dly_max) : 0;
            resp_addr = node_addr;
            if (nreads == 0) first_read = node_addr;
            nreads++;
            last_read = node_addr;
         end
         @(posedge clk); #1;
         if (mem_stall || (resp_pend && resp_addr == stall_addr)) resp_pend = 1'b0;
         if (resp_pend && resp_cnt == 0) begin
            feature_idx = mem[resp_addr].fidx;
            threshold   = mem[resp_addr].thr;
            left_child  = mem[resp_addr].l;
            right_child = mem[resp_addr].r;
            prediction  = mem[resp_addr].pred;
            is_leaf     = mem[resp_addr].leaf;
            data_valid  = 1'b1;
            resp_pend   = 1'b0;
         end else begin
            if (resp_pend) resp_cnt--;
            feature_idx = 2'($urandom_range(0, 3));
            threshold   = {$urandom, $urandom};
            left_child  = 9'($urandom_range(1, 511));
            right_child = 9'($urandom_range(0, 511));
            prediction  = inj_dv ? 2'b11 : 2'($urandom_range(0, 3));
            is_leaf     = inj_dv ? 1'b1 : 1'($urandom_range(0, 1));
            data_valid  = inj_dv;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] mkf(input logic [63:0] f0, input logic [63:0] f1,
                                        input logic [63:0] f2, input logic [63:0] f3);
      return {f3, f2, f1, f0};
   endfunction

   function automatic node_t mkn(input logic leaf, input logic [1:0] pred, input logic [1:0] fidx,
                                 input logic [63:0] thr, input logic [8:0] l, input logic [8:0] r);
      node_t n;
      n.leaf = leaf; n.pred = pred; n.fidx = fidx; n.thr = thr; n.l = l; n.r = r;
      return n;
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 512; i++) mem[i] = '0;
   endtask

   task automatic setup_tree(input int id);
      clear_mem();
      case (id)
         0: mem[0] = mkn(1'b1, 2'b10, 2'd0, 64'd0, 9'd0, 9'd0);
         1: begin
            mem[0] = mkn(1'b0, 2'b00, 2'd1, 64'h100, 9'd1, 9'd2);
            mem[1] = mkn(1'b1, 2'b11, 2'd0, 64'd0, 9'd0, 9'd0);
            mem[2] = mkn(1'b1, 2'b01, 2'd0, 64'd0, 9'd0, 9'd0);
         end
         2: begin
            for (int k = 0; k < 4; k++)
               mem[k] = mkn(1'b0, 2'b00, 2'd0, '1, 9'(k + 1), 9'(k + 1));
            mem[4] = mkn(1'b1, 2'b11, 2'd0, 64'd0, 9'd0, 9'd0);
         end
         default: begin
            mem[0] = mkn(1'b0, 2'b00, 2'd0, 64'd5, 9'd5, 9'd0);
            mem[5] = mkn(1'b1, 2'b01, 2'd0, 64'd0, 9'd0, 9'd0);
         end
      endcase
   endtask

   task automatic start_vec(input logic [255:0] f);
      int guard = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) begin
         total++; bad++;
         $display("FAIL ready_wait: got in_ready=%b expected 1 within 100 cycles", in_ready);
      end
      in_features = f;
      in_valid    = 1'b1;
      nreads      = 0;
      @(posedge clk); #1;
      in_valid    = 1'b0;
      in_features = {8{$urandom}};
   endtask

   // Counts posedges from the accept edge (inclusive) until result_valid is seen.
   task automatic wait_result(output int lat);
      lat = 1;
      @(negedge clk);
      while (result_valid !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      if (lat >= 200) begin
         total++; bad++;
         $display("FAIL result_wait: got no result_valid expected one within 200 cycles");
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_node_addr"}, 64'(node_addr), 64'd0);
      check({tag, "_read_en"},   64'(read_enable), 64'd0);
      check({tag, "_rvalid"},    64'(result_valid), 64'd0);
      check({tag, "_busy"},      64'(busy), 64'd0);
      check({tag, "_in_ready"},  64'(in_ready), 64'd1);
      check({tag, "_outs"},      64'({result_class, result_error, result_depth}), 64'd0);
   endtask

   // Reference walk straight from the traversal rules, over the bench's node table.
   function automatic void ref_walk(input logic [255:0] f, output logic [1:0] cls,
                                    output logic [1:0] err, output int dep);
      logic [8:0]  a = 9'd0;
      logic [63:0] sel;
      node_t       nd;
      cls = 2'b00; err = 2'b00; dep = 0;
      for (int step = 0; step < 256; step++) begin
         dep++;
         nd = mem[a];
         if (nd.leaf) begin cls = nd.pred; return; end
         if ((nd.l == 0) != (nd.r == 0)) begin err = 2'b11; return; end
         if (dep == MAXD) begin err = 2'b01; return; end
         sel = f[nd.fidx*64 +: 64];
         a = (sel <= nd.thr) ? nd.l : nd.r;
      end
   endfunction

   // ---------------- main sequence ----------------
   vec_t vecs [7];

   initial begin
      int lat;
      int guard;
      logic [1:0] ecls, eerr;
      int edep;
      logic [255:0] f;

      vecs[0] = '{0, mkf(0, 0, 0, 0),                      2'b10, 2'b00, 1, 3, 1, 0};
      vecs[1] = '{1, mkf(0, 64'h101, 0, 0),                2'b01, 2'b00, 2, 5, 2, 2};
      vecs[2] = '{1, mkf('1, 64'h100, '1, '1),             2'b11, 2'b00, 2, 5, 2, 1};
      vecs[3] = '{1, mkf(0, 64'h8000_0000_0000_0000, 0, 0), 2'b01, 2'b00, 2, 5, 2, 2};
      vecs[4] = '{1, mkf('1, 64'hFF, '1, '1),              2'b11, 2'b00, 2, 5, 2, 1};
      vecs[5] = '{2, mkf(64'h1234, 0, 0, 0),               2'b00, 2'b01, 4, 9, 4, 3};
      vecs[6] = '{3, mkf(0, 0, 0, 0),                      2'b00, 2'b11, 1, 3, 1, 0};

      repeat (3) @(negedge clk);
      check_reset_state("por");
      rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < 7; i++) begin
         setup_tree(vecs[i].tree);
         start_vec(vecs[i].feat);
         wait_result(lat);
         check($sformatf("v%0d_class", i), 64'(result_class), 64'(vecs[i].cls));
         check($sformatf("v%0d_err", i),   64'(result_error), 64'(vecs[i].err));
         check($sformatf("v%0d_depth", i), 64'(result_depth), 64'(vecs[i].dep));
         check($sformatf("v%0d_lat", i),   64'(lat),          64'(vecs[i].lat));
         check($sformatf("v%0d_reads", i), 64'(nreads),       64'(vecs[i].reads));
         check($sformatf("v%0d_last", i),  64'(last_read),    64'(vecs[i].last));
         @(negedge clk);
         check($sformatf("v%0d_idle", i), 64'({in_ready, result_valid}), 64'b10);
      end

      // Memory stall -> timeout, then late data_valid in DONE and IDLE is ignored
      setup_tree(0);
      mem_stall = 1'b1;
      result_ready = 1'b0;
      start_vec(mkf(0, 0, 0, 0));
      wait_result(lat);
      mem_stall = 1'b0;
      check("tmo_err",   64'(result_error), 64'b10);
      check("tmo_class", 64'(result_class), 64'b00);
      check("tmo_depth", 64'(result_depth), 64'd1);
      check("tmo_lat",   64'(lat), 64'(TMO + 2));
      inj_dv = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("late_dv_done", 64'({result_valid, result_class, result_error}), 64'b1_00_10);
      end
      inj_dv = 1'b0;
      result_ready = 1'b1;
      @(negedge clk);
      inj_dv = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("late_dv_idle", 64'({busy, read_enable, in_ready}), 64'b001);
      end
      inj_dv = 1'b0;
      @(negedge clk);

      // Backpressure on a bad node; offered input while busy must not be taken
      setup_tree(3);
      result_ready = 1'b0;
      start_vec(mkf(0, 0, 0, 0));
      wait_result(lat);
      check("bp_err", 64'(result_error), 64'b11);
      in_valid = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check("bp_hold", 64'({result_valid, in_ready, result_class, result_error, result_depth}),
               64'({1'b1, 1'b0, 2'b00, 2'b11, 8'd1}));
      end
      in_valid = 1'b0;
      result_ready = 1'b1;
      @(negedge clk);
      check("bp_release", 64'({result_valid, in_ready, busy}), 64'b010);

      // Reset while waiting on the second node, then a clean walk from root
      setup_tree(1);
      stall_addr = 9'd2;
      start_vec(mkf(0, 64'h101, 0, 0));
      guard = 0;
      while (nreads < 2 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("rst_reached_n2", 64'(nreads), 64'd2);
      @(negedge clk);
      check("rst_pre_busy", 64'({busy, node_addr}), 64'({1'b1, 9'd2}));
      #2 rst_n = 1'b0;
      #1 check_reset_state("midwait");
      stall_addr = 9'h1FF;
      @(negedge clk);
      rst_n = 1'b1;
      start_vec(mkf(0, 64'h101, 0, 0));
      wait_result(lat);
      check("post_rst_first", 64'(first_read), 64'd0);
      check("post_rst_last",  64'(last_read), 64'd2);
      check("post_rst_res",   64'({result_class, result_error, result_depth}),
            64'({2'b01, 2'b00, 8'd2}));
      check("post_rst_lat",   64'(lat), 64'd5);

      // Randomized trees with random memory delay, against the reference walk
      dly_max = 3;
      for (int t = 0; t < 40; t++) begin
         clear_mem();
         for (int a = 0; a < 16; a++)
            mem[a] = mkn(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                         2'($urandom_range(0, 3)), {$urandom, $urandom},
                         9'($urandom_range(0, 15)), 9'($urandom_range(0, 15)));
         for (int k = 0; k < 4; k++) begin
            case ($urandom_range(0, 3))
               0:       f[k*64 +: 64] = mem[$urandom_range(0, 15)].thr;
               1:       f[k*64 +: 64] = mem[$urandom_range(0, 15)].thr + 64'd1;
               default: f[k*64 +: 64] = {$urandom, $urandom};
            endcase
         end
         ref_walk(f, ecls, eerr, edep);
         start_vec(f);
         wait_result(lat);
         check($sformatf("rnd%0d_res", t), 64'({result_class, result_error, result_depth}),
               64'({ecls, eerr, 8'(edep)}));
         check($sformatf("rnd%0d_reads", t), 64'(nreads), 64'(edep));
      end
      dly_max = 0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
